currency_ledger: RTL

//  Registered player bankroll for the blackjack game. Accepts one command at a time from the game FSM:

---
 rtl/currency_ledger_pkg.sv | 19 +
 rtl/currency_ledger_if.sv | 22 ++
 rtl/currency_ledger_adder.sv | 19 +
 rtl/currency_ledger.sv | 102 ++++++++++
 4 files changed

// File: rtl/currency_ledger_pkg.sv
// currency_ledger_pkg: shared opcodes and FSM state encoding for the bankroll ledger and game FSM.
package currency_ledger_pkg;
    localparam logic [2:0] OP_BET       = 3'd0;
    localparam logic [2:0] OP_WIN       = 3'd1;
    localparam logic [2:0] OP_BLACKJACK = 3'd2;
    localparam logic [2:0] OP_PUSH      = 3'd3;
    localparam logic [2:0] OP_LOSE      = 3'd4;
    localparam logic [2:0] OP_RELOAD    = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

    function automatic logic is_settle(input logic [2:0] op);
        return op inside {OP_WIN, OP_BLACKJACK, OP_PUSH, OP_LOSE};
    endfunction
endpackage

// File: rtl/currency_ledger_if.sv
// currency_ledger_if: command handshake and bankroll status between game FSM and ledger.
interface currency_ledger_if #(parameter int WIDTH = 16);
    logic             cmd_valid;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_amount;
    logic             cmd_ready;
    logic             done;
    logic             err;
    logic             sat;
    logic [WIDTH-1:0] balance;
    logic [WIDTH-1:0] escrow;
    logic             broke;

    modport master (
        output cmd_valid, cmd_op, cmd_amount,
        input  cmd_ready, done, err, sat, balance, escrow, broke
    );
    modport slave (
        input  cmd_valid, cmd_op, cmd_amount,
        output cmd_ready, done, err, sat, balance, escrow, broke
    );
endinterface

// File: rtl/currency_ledger_adder.sv
// ripple_adder_n: N-bit ripple-carry chain of 1-bit full-adder cells.
module ripple_adder_n #(
    parameter int N = 18
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         cin,
    output logic [N-1:0] S,
    output logic         cout
);
    logic [N:0] c;

    assign c[0] = cin;
    for (genvar i = 0; i < N; i++) begin : g_fa
        assign S[i]   = A[i] ^ B[i] ^ c[i];
        assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end
    assign cout = c[N];
endmodule

// File: rtl/currency_ledger.sv
// currency_ledger: registered bankroll with bet escrow, settled through one ripple adder in a 3-state FSM.
module currency_ledger
    import currency_ledger_pkg::*;
#(
    parameter int WIDTH         = 16,
    parameter int START_BALANCE = 100
) (
    input logic               clk,
    input logic               reset,
    currency_ledger_if.slave  bus
);
    localparam int               N     = WIDTH + 2;
    localparam logic [WIDTH-1:0] START = WIDTH'(START_BALANCE);
    localparam logic [WIDTH-1:0] MAXV  = '1;

    state_e           state_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] amt_q, bal_q, esc_q, nbal_q, nesc_q;
    logic             done_q, err_q, sat_q, nerr_q, nsat_q;
    logic [N-1:0]     add_a, add_b, sum;
    logic             add_cin, cout, credit;
    logic             nerr_d, nsat_d;
    logic [WIDTH-1:0] nbal_d, nesc_d;

    assign credit  = op_q inside {OP_WIN, OP_BLACKJACK, OP_PUSH};
    assign add_a   = {2'b00, bal_q};
    assign add_cin = op_q == OP_BET;
    // BET subtracts via A + ~B + 1; cout=1 then means balance >= amount
    assign add_b   = op_q == OP_BET       ? ~{2'b00, amt_q} :
                     op_q == OP_WIN       ? {1'b0, esc_q, 1'b0} :
                     op_q == OP_BLACKJACK ? {1'b0, esc_q, 1'b0} + {3'b000, esc_q[WIDTH-1:1]} :
                     op_q == OP_PUSH      ? {2'b00, esc_q} : '0;

    ripple_adder_n #(.N(N)) u_add (
        .A    (add_a),
        .B    (add_b),
        .cin  (add_cin),
        .S    (sum),
        .cout (cout)
    );

    always_comb begin
        nerr_d = op_q == OP_BET    ? (amt_q == '0) || !cout || (esc_q != '0) :
                 is_settle(op_q)   ? esc_q == '0 :
                 op_q != OP_RELOAD;
        nsat_d = credit && !nerr_d && (sum[N-1:WIDTH] != '0);
        nbal_d = op_q == OP_RELOAD ? START : nsat_d ? MAXV : sum[WIDTH-1:0];
        nesc_d = op_q == OP_BET ? amt_q : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            amt_q   <= '0;
            bal_q   <= START;
            esc_q   <= '0;
            nbal_q  <= '0;
            nesc_q  <= '0;
            nerr_q  <= 1'b0;
            nsat_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: if (bus.cmd_valid) begin
                    op_q    <= bus.cmd_op;
                    amt_q   <= bus.cmd_amount;
                    state_q <= ST_CALC;
                end
                ST_CALC: begin
                    nerr_q  <= nerr_d;
                    nsat_q  <= nsat_d;
                    nbal_q  <= nbal_d;
                    nesc_q  <= nesc_d;
                    state_q <= ST_WRITE;
                end
                ST_WRITE: begin
                    done_q <= 1'b1;
                    err_q  <= nerr_q;
                    sat_q  <= nsat_q;
                    if (!nerr_q) begin
                        bal_q <= nbal_q;
                        esc_q <= nesc_q;
                    end
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = state_q == ST_IDLE;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.sat       = sat_q;
    assign bus.balance   = bal_q;
    assign bus.escrow    = esc_q;
    assign bus.broke     = (bal_q == '0) && (esc_q == '0);
endmodule
